// File: rtl/latch_ctrl_pkg.sv
// Shared types and elaboration helpers for the latch bank write controller.
package latch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_OPEN,
        ST_HOLD
    } state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic bit cyc_params_ok(input int unsigned setup_cyc,
                                         input int unsigned open_cyc,
                                         input int unsigned hold_cyc);
        return (setup_cyc >= 1) && (open_cyc >= 1) && (hold_cyc >= 1);
    endfunction

endpackage

// File: rtl/latch_bank_ctrl_if.sv
// Requester handshake and latch-bank pin bundle for latch_bank_ctrl.
interface latch_bank_ctrl_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned NLAT = 4,
    parameter int unsigned AW   = 2,
    parameter int unsigned DW   = 8
);
    logic [NREQ-1:0]    REQ;
    logic [NREQ*AW-1:0] ADDR;
    logic [NREQ*DW-1:0] WDATA;
    logic [NREQ-1:0]    GNT;
    logic [NREQ-1:0]    ACK;
    logic               ERR;
    logic [DW-1:0]      LAT_D;
    logic [NLAT-1:0]    LAT_EN;
    logic               BUSY;

    modport master (output REQ, ADDR, WDATA,
                    input  GNT, ACK, ERR, BUSY);

    modport slave  (input  REQ, ADDR, WDATA,
                    output GNT, ACK, ERR, LAT_D, LAT_EN, BUSY);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: search upward from ptr+1 with wrap; only active while advance is high.
module rr_arbiter
    import latch_ctrl_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = (clog2(NREQ) > 0) ? clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            advance,
    output logic [NREQ-1:0] grant_c,
    output logic [IW-1:0]   idx_c
);

    int unsigned cand;
    logic        found;

    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        cand    = 0;
        found   = 1'b0;
        if (advance) begin
            for (int unsigned off = 1; off <= NREQ; off++) begin
                cand = 32'(ptr) + off;
                if (cand >= NREQ) cand = cand - NREQ;
                if (!found && req[cand]) begin
                    grant_c[cand] = 1'b1;
                    idx_c         = IW'(cand);
                    found         = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Write sequencer for a shared bank of transparent latches: arbitrates requesters and
// drives data/enable with programmable setup, open and hold windows.
module latch_bank_ctrl
    import latch_ctrl_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned NLAT      = 4,
    parameter int unsigned AW        = 2,
    parameter int unsigned DW        = 8,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned OPEN_CYC  = 1,
    parameter int unsigned HOLD_CYC  = 1
) (
    input logic              CK,
    input logic              RSTB,
    latch_bank_ctrl_if.slave bus
);

    localparam int unsigned IW = (clog2(NREQ) > 0) ? clog2(NREQ) : 1;
    localparam int unsigned CW = clog2(max3(SETUP_CYC, OPEN_CYC, HOLD_CYC)) + 1;

    if (!cyc_params_ok(SETUP_CYC, OPEN_CYC, HOLD_CYC)) begin : g_bad_cyc
        $error("latch_bank_ctrl: SETUP_CYC, OPEN_CYC and HOLD_CYC must all be >= 1");
    end

    state_e            state_q, state_nx;
    logic [CW-1:0]     cnt_q, cnt_nx;
    logic [IW-1:0]     ptr_q, ptr_nx;
    logic [IW-1:0]     idx_q, idx_nx;
    logic [AW-1:0]     addr_q, addr_nx;
    logic [NREQ-1:0]   gnt_q, gnt_nx;
    logic [NREQ-1:0]   ack_q, ack_nx;
    logic              err_q, err_nx;
    logic [DW-1:0]     lat_d_q, lat_d_nx;
    logic [NLAT-1:0]   lat_en_q, lat_en_nx;
    logic              busy_q, busy_nx;

    logic [NREQ-1:0]   arb_grant_c;
    logic [IW-1:0]     arb_idx_c;
    logic              arb_en_c;
    logic [NLAT-1:0]   addr_dec_c;
    logic              addr_oor_c;

    assign arb_en_c = (state_q == ST_IDLE);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (bus.REQ),
        .ptr     (ptr_q),
        .advance (arb_en_c),
        .grant_c (arb_grant_c),
        .idx_c   (arb_idx_c)
    );

    // Out-of-range addresses decode to no enable at all.
    always_comb begin
        addr_dec_c = '0;
        for (int unsigned w = 0; w < NLAT; w++) begin
            addr_dec_c[w] = (32'(addr_q) == w);
        end
    end
    assign addr_oor_c = (32'(addr_q) >= NLAT);

    always_comb begin
        state_nx  = state_q;
        cnt_nx    = cnt_q;
        ptr_nx    = ptr_q;
        idx_nx    = idx_q;
        addr_nx   = addr_q;
        gnt_nx    = gnt_q;
        ack_nx    = '0;
        err_nx    = 1'b0;
        lat_d_nx  = lat_d_q;
        lat_en_nx = '0;
        busy_nx   = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|arb_grant_c) begin
                    state_nx = ST_SETUP;
                    cnt_nx   = '0;
                    idx_nx   = arb_idx_c;
                    addr_nx  = bus.ADDR[32'(arb_idx_c)*AW +: AW];
                    lat_d_nx = bus.WDATA[32'(arb_idx_c)*DW +: DW];
                    gnt_nx   = arb_grant_c;
                    busy_nx  = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CW'(SETUP_CYC - 1)) begin
                    state_nx  = ST_OPEN;
                    cnt_nx    = '0;
                    lat_en_nx = addr_dec_c;
                end else begin
                    cnt_nx = cnt_q + CW'(1);
                end
            end
            ST_OPEN: begin
                if (cnt_q == CW'(OPEN_CYC - 1)) begin
                    state_nx = ST_HOLD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx    = cnt_q + CW'(1);
                    lat_en_nx = addr_dec_c;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CW'(HOLD_CYC - 1)) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                    gnt_nx   = '0;
                    busy_nx  = 1'b0;
                    ack_nx   = gnt_q;
                    err_nx   = addr_oor_c;
                    ptr_nx   = idx_q;
                end else begin
                    cnt_nx = cnt_q + CW'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Reset starts the pointer at the last requester so requester 0 wins first.
    always_ff @(posedge CK or negedge RSTB) begin
        if (!RSTB) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ptr_q    <= IW'(NREQ - 1);
            idx_q    <= '0;
            addr_q   <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            lat_d_q  <= '0;
            lat_en_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_nx;
            cnt_q    <= cnt_nx;
            ptr_q    <= ptr_nx;
            idx_q    <= idx_nx;
            addr_q   <= addr_nx;
            gnt_q    <= gnt_nx;
            ack_q    <= ack_nx;
            err_q    <= err_nx;
            lat_d_q  <= lat_d_nx;
            lat_en_q <= lat_en_nx;
            busy_q   <= busy_nx;
        end
    end

    assign bus.GNT    = gnt_q;
    assign bus.ACK    = ack_q;
    assign bus.ERR    = err_q;
    assign bus.LAT_D  = lat_d_q;
    assign bus.LAT_EN = lat_en_q;
    assign bus.BUSY   = busy_q;

endmodule

// File: doc/latch_bank_ctrl.md
# latch_bank_ctrl

Write sequencer and round-robin arbiter for a shared bank of transparent `Latch` cells (ports `CK`, `D`, `Q`). Up to `NREQ` requesters post single-word writes; the block grants one at a time. For each grant it drives the shared latch data bus and pulses exactly one latch enable, with programmable setup, open and hold windows. Sits between client logic and the latch register bank; all timing at the latch pins is owned here.

## Interface
- `NREQ`, 4, number of requesters (≥2)
- `NLAT`, 4, number of latch words in the bank (≥1)
- `AW`, 2, address width per requester
- `DW`, 8, data width
- `SETUP_CYC`, 1, cycles `LAT_D` is stable before enable (≥1)
- `OPEN_CYC`, 1, cycles enable is high (≥1)
- `HOLD_CYC`, 1, cycles `LAT_D` is held after enable falls (≥1)

Ports:
- `CK`  in  1  clock, rising edge
- `RSTB`  in  1  asynchronous reset, active-low
- `REQ`  in  NREQ  write request, one bit per requester
- `ADDR`  in  NREQ*AW  target latch word, requester i at bits [i*AW +: AW]
- `WDATA`  in  NREQ*DW  write data, requester i at bits [i*DW +: DW]
- `GNT`  out  NREQ  one-hot grant, held for the whole transaction
- `ACK`  out  NREQ  one-cycle completion pulse to the granted requester
- `ERR`  out  1  one-cycle pulse coincident with `ACK` when the address was ≥ `NLAT`
- `LAT_D`  out  DW  shared data bus to all latch `D` pins
- `LAT_EN`  out  NLAT  per-word latch enable, at most one bit high
- `BUSY`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SETUP, OPEN, HOLD. One phase counter is shared by SETUP, OPEN and HOLD.
- IDLE: if any `REQ` bit is high at the rising edge:
  - Grant the round-robin winner, searching from last-granted+1 upward with wrap.
  - Capture its `ADDR`/`WDATA` into internal registers.
  - Set `GNT[i]`, go to SETUP.
- SETUP: `LAT_D` = captured data; `LAT_EN` = 0. Lasts `SETUP_CYC` cycles, then OPEN.
- OPEN: `LAT_EN[addr]` = 1 (all zero if addr ≥ `NLAT`); `LAT_D` unchanged. Lasts `OPEN_CYC` cycles, then HOLD.
- HOLD: `LAT_EN` = 0; `LAT_D` unchanged. Lasts `HOLD_CYC` cycles, then IDLE.
- On the HOLD→IDLE edge:
  - `GNT` clears.
  - `ACK[i]` goes high for one cycle.
  - `ERR` goes high for that cycle if the address was out of range.
  - The last-granted pointer updates to i.
- Handshake rules:
  - A requester holds `REQ`/`ADDR`/`WDATA` until granted.
  - Dropping `REQ` before grant withdraws the request.
  - Dropping `REQ` after grant has no effect; the captured write completes and `ACK` is still issued.
  - A requester may re-assert `REQ` in its `ACK` cycle.
- `LAT_D` holds its last value in IDLE (no glitching of the latch inputs).
- Simultaneous requests are resolved by the round-robin pointer only; no fixed priority after reset.

## Timing
- Reset (`RSTB`=0, asynchronous):
  - FSM→IDLE, counter→0.
  - `GNT`, `ACK`, `ERR`, `LAT_EN`, `BUSY`, `LAT_D` → 0.
  - Pointer→`NREQ-1`, so requester 0 wins first.
- Reset mid-transaction aborts it: enable drops immediately and no `ACK` is issued.
- Latency, for `REQ` seen at edge k:
  - `GNT` high after edge k.
  - `LAT_EN` high after edge k+`SETUP_CYC`.
  - `ACK` high after edge k+`SETUP_CYC`+`OPEN_CYC`+`HOLD_CYC`.
- With defaults: grant at k, enable during cycle k+1..k+2, `ACK` after k+3.
- Back-to-back throughput: the next grant is taken at the edge that ends the `ACK` cycle (one IDLE cycle). Period = 1+`SETUP_CYC`+`OPEN_CYC`+`HOLD_CYC` = 4 cycles at defaults.
- All outputs are registered; none is combinational from `REQ`.
- Phase counter width = clog2(max(`SETUP_CYC`,`OPEN_CYC`,`HOLD_CYC`))+1; no wrap is possible.

## Structure
- Package `latch_ctrl_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_SETUP`, `ST_OPEN`, `ST_HOLD`).
  - clog2 helper function.
  - Elaboration-time check that each `*_CYC` parameter is ≥1.
- Sub-module `rr_arbiter` (`NREQ`): inputs request vector, pointer and advance strobe; outputs one-hot winner and winner index. The controller instantiates it once.

## Test plan
- Single write: after reset, `REQ[2]`=1, `ADDR`=3, `WDATA`=8'hA5 → `GNT[2]` after 1 edge; `LAT_EN`=4'b1000 for exactly 1 cycle with `LAT_D`=8'hA5 one cycle before and after; `ACK[2]` pulses 4 cycles after request; a `Latch` model holds 8'hA5.
- Round-robin: all four `REQ` held high → grant order 0,1,2,3,0 with one `ACK` every 4 cycles, never two `GNT` bits set.
- Windows: `SETUP_CYC`=2, `OPEN_CYC`=3, `HOLD_CYC`=2 → enable high 3 cycles, `LAT_D` stable from 2 cycles before to 2 cycles after, `ACK` 7 edges after grant.
- Out-of-range: `NLAT`=3, `ADDR`=3 → `LAT_EN` stays 0, `ACK` and `ERR` pulse together, latch contents unchanged.
- Withdraw and abort:
  - `REQ[1]` dropped before grant → no `GNT[1]`.
  - `RSTB` pulsed low during OPEN → `LAT_EN`/`GNT` drop immediately, no `ACK`.
  - First grant after reset goes to requester 0.
